// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_receiver
//  Description : Receive-side VGA timing monitor. Samples an hsync/vsync/
//                bright/rgb stream on pixel-clock-enable cycles, rebuilds the
//                visible pixel position, measures line length and frame
//                height, checks them against nominal timing and declares
//                lock after LOCK_FRAMES consecutive good frames.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock
//    rst          in   asynchronous active-high reset
//    pix_ce       in   pixel clock enable; all state advances only when 1
//    hsync_n      in   active-low horizontal sync
//    vsync_n      in   active-low vertical sync
//    bright       in   visible-region flag
//    rgb[11:0]    in   pixel colour {R,G,B}
//    h_pos[9:0]   out  reconstructed visible column
//    v_pos[9:0]   out  reconstructed visible row
//    pos_valid    out  h_pos/v_pos valid (bright and locked)
//    line_len     out  last measured line length in ce cycles
//    frame_lines  out  last measured lines per frame
//    locked       out  timing lock
//    err_count    out  saturating timing error count
//    frame_done   out  one-clk pulse per vsync falling edge
//    frame_sum    out  (VGA_RX_CHECKSUM_EN only) per-frame colour checksum
//
//  Build option
//    VGA_RX_CHECKSUM_EN : adds frame_sum, the modulo-2^16 sum of rgb over all
//                         bright pixels of the previous frame.
// ============================================================================
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_OFFSET    = 144,
    parameter int V_OFFSET    = 35,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        bright,
    input  logic [11:0] rgb,
    output logic [9:0]  h_pos,
    output logic [9:0]  v_pos,
    output logic        pos_valid,
    output logic [9:0]  line_len,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic [7:0]  err_count,
`ifdef VGA_RX_CHECKSUM_EN
    output logic [15:0] frame_sum,
`endif
    output logic        frame_done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  ST_SEARCH  = 2'd0;
    localparam logic [1:0]  ST_ACQUIRE = 2'd1;
    localparam logic [1:0]  ST_LOCKED  = 2'd2;

    localparam logic [9:0]  C_CNT_MAX  = 10'h3FF;
    localparam logic [10:0] C_H_TOTAL  = 11'(H_TOTAL);
    localparam logic [10:0] C_V_TOTAL  = 11'(V_TOTAL);
    localparam logic [9:0]  C_H_OFFSET = 10'(H_OFFSET);
    localparam logic [9:0]  C_V_OFFSET = 10'(V_OFFSET);
    localparam logic [3:0]  C_LOCK     = 4'(LOCK_FRAMES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        hs_prev_q,     hs_prev_d;
    logic        vs_prev_q,     vs_prev_d;
    logic [9:0]  h_cnt_q,       h_cnt_d;
    logic [9:0]  v_cnt_q,       v_cnt_d;
    logic [9:0]  line_len_q,    line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic        line_err_q,    line_err_d;
    logic [9:0]  h_pos_q,       h_pos_d;
    logic [9:0]  v_pos_q,       v_pos_d;
    logic        pos_valid_q,   pos_valid_d;
    logic [1:0]  state_q,       state_d;
    logic [3:0]  good_cnt_q,    good_cnt_d;
    logic        locked_q,      locked_d;
    logic [7:0]  err_count_q,   err_count_d;
    logic        frame_done_q,  frame_done_d;

    // ------------------------------------------------------------------------
    // Edge detection and measurement candidates
    // ------------------------------------------------------------------------
    logic        hs_fall;
    logic        vs_fall;
    logic        sync_loss;
    logic [10:0] line_cand;
    logic [10:0] frame_cand;
    logic        line_bad;
    logic        frame_good;
    logic [3:0]  good_cnt_inc;
    logic        err_inc;

    assign hs_fall      = pix_ce & hs_prev_q & ~hsync_n;
    assign vs_fall      = pix_ce & vs_prev_q & ~vsync_n;
    // A saturated horizontal counter means hsync has vanished for longer
    // than any legal line.
    assign sync_loss    = pix_ce & (h_cnt_q == C_CNT_MAX);
    // 11-bit candidates so that a saturated count (1023+1) never aliases
    // onto a small legal value.
    assign line_cand    = {1'b0, h_cnt_q} + 11'd1;
    assign frame_cand   = {1'b0, v_cnt_q} + {10'd0, hs_fall};
    assign line_bad     = hs_fall & (line_cand != C_H_TOTAL);
    // The line closed on the same ce as vs_fall belongs to the old frame,
    // so its error takes part in this frame's verdict.
    assign frame_good   = (frame_cand == C_V_TOTAL) & ~(line_err_q | line_bad);
    assign good_cnt_inc = good_cnt_q + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        line_err_d    = line_err_q;
        h_pos_d       = h_pos_q;
        v_pos_d       = v_pos_q;
        pos_valid_d   = pos_valid_q;
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        err_count_d   = err_count_q;
        err_inc       = 1'b0;

        if (pix_ce) begin
            hs_prev_d = hsync_n;
            vs_prev_d = vsync_n;

            // Horizontal counter: restart on hsync fall, otherwise saturate.
            if (hs_fall) begin
                h_cnt_d    = 10'd0;
                line_len_d = line_cand[9:0];
            end else if (h_cnt_q != C_CNT_MAX) begin
                h_cnt_d = h_cnt_q + 10'd1;
            end

            // Vertical counter: a coincident hsync fall is credited to the
            // frame that is ending (already folded into frame_cand).
            if (vs_fall) begin
                v_cnt_d       = 10'd0;
                frame_lines_d = frame_cand[9:0];
            end else if (hs_fall) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end

            if (vs_fall) begin
                line_err_d = 1'b0;
            end else if (line_bad) begin
                line_err_d = 1'b1;
            end

            // Position is that of the pixel sampled on this ce, i.e. the
            // value the counters take after this cycle.
            h_pos_d     = h_cnt_d - C_H_OFFSET;
            v_pos_d     = v_cnt_d - C_V_OFFSET;
            pos_valid_d = bright & locked_q;

            // Lock FSM. Sync loss overrides any frame verdict on the same ce.
            if (sync_loss) begin
                state_d    = ST_SEARCH;
                good_cnt_d = 4'd0;
                err_inc    = (state_q == ST_LOCKED);
            end else if (vs_fall) begin
                case (state_q)
                    ST_SEARCH: begin
                        // First edge after search only aligns; the partial
                        // frame before it carries no information.
                        state_d    = ST_ACQUIRE;
                        good_cnt_d = 4'd0;
                    end
                    ST_ACQUIRE: begin
                        if (frame_good) begin
                            if (good_cnt_inc >= C_LOCK) begin
                                state_d    = ST_LOCKED;
                                good_cnt_d = 4'd0;
                            end else begin
                                good_cnt_d = good_cnt_inc;
                            end
                        end else begin
                            good_cnt_d = 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!frame_good) begin
                            state_d    = ST_ACQUIRE;
                            good_cnt_d = 4'd0;
                            err_inc    = 1'b1;
                        end
                    end
                    default: begin
                        state_d    = ST_SEARCH;
                        good_cnt_d = 4'd0;
                    end
                endcase
            end

            if (err_inc && (err_count_q != 8'hFF)) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        locked_d = (state_d == ST_LOCKED);
        // Pulses one clk after vs_fall regardless of pix_ce in that clk.
        frame_done_d = vs_fall;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            line_err_q    <= 1'b0;
            h_pos_q       <= 10'd0;
            v_pos_q       <= 10'd0;
            pos_valid_q   <= 1'b0;
            state_q       <= ST_SEARCH;
            good_cnt_q    <= 4'd0;
            locked_q      <= 1'b0;
            err_count_q   <= 8'd0;
            frame_done_q  <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            line_err_q    <= line_err_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            pos_valid_q   <= pos_valid_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            locked_q      <= locked_d;
            err_count_q   <= err_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    // ------------------------------------------------------------------------
    // Per-frame colour checksum
    // ------------------------------------------------------------------------
    logic [15:0] acc_q,       acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [15:0] sum_cur;

    assign sum_cur = acc_q + (bright ? {4'd0, rgb} : 16'd0);

    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        if (pix_ce) begin
            if (vs_fall) begin
                frame_sum_d = sum_cur;
                acc_d       = 16'd0;
            end else begin
                acc_d = sum_cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= 16'd0;
            frame_sum_q <= 16'd0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign h_pos       = h_pos_q;
    assign v_pos       = v_pos_q;
    assign pos_valid   = pos_valid_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign locked      = locked_q;
    assign err_count   = err_count_q;
    assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_receiver
//  Description : Self-checking bench for vga_sync_receiver. A stream
//                generator drives reduced-size frames; a frame-level model
//                predicts per-frame results and per-pixel positions, which
//                two monitors compare against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_receiver;

    localparam int H_T   = 40;
    localparam int V_T   = 16;
    localparam int H_OFF = 10;
    localparam int V_OFF = 3;
    localparam int LOCKF = 2;
    localparam int H_VIS = 28;
    localparam int V_VIS = 12;
    localparam int HS_W  = 4;
    localparam int VS_W  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic        hsync_n = 1'b1;
    logic        vsync_n = 1'b1;
    logic        bright = 1'b0;
    logic [11:0] rgb = 12'd0;
    logic [9:0]  h_pos, v_pos, line_len, frame_lines;
    logic        pos_valid, locked, frame_done;
    logic [7:0]  err_count;
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    vga_sync_receiver #(
        .H_TOTAL(H_T), .V_TOTAL(V_T), .H_OFFSET(H_OFF),
        .V_OFFSET(V_OFF), .LOCK_FRAMES(LOCKF)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync_n(hsync_n),
        .vsync_n(vsync_n), .bright(bright), .rgb(rgb),
        .h_pos(h_pos), .v_pos(v_pos), .pos_valid(pos_valid),
        .line_len(line_len), .frame_lines(frame_lines), .locked(locked),
        .err_count(err_count),
`ifdef VGA_RX_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct { bit meas; int fl; int ll; bit lk; int err; int sum; } fexp_t;
    typedef struct { bit pv; int h; int v; } pexp_t;
    fexp_t fq[$];
    pexp_t pq[$];

    // ---------------- frame-level reference model ----------------
    bit m_search = 1'b1;
    bit m_locked = 1'b0;
    int m_streak = 0;
    int m_err    = 0;
    int f_lines  = 0;
    int f_last   = 0;
    bit f_good   = 1'b1;
    int f_sum    = 0;
    bit gap_fixed = 1'b1;

    function automatic void model_clear_frame();
        f_lines = 0; f_last = 0; f_good = 1'b1; f_sum = 0;
    endfunction

    function automatic void model_vs_fall();
        fexp_t e;
        e = '{meas: 1'b0, fl: 0, ll: 0, lk: 1'b0, err: 0, sum: 0};
        if (m_search) begin
            m_search = 1'b0;
            m_streak = 0;
        end else begin
            e.meas = 1'b1;
            e.fl = f_lines;
            e.ll = f_last;
            e.sum = f_sum;
            if (f_good && f_lines == V_T) begin
                if (!m_locked) begin
                    m_streak++;
                    if (m_streak >= LOCKF) m_locked = 1'b1;
                end
            end else begin
                m_streak = 0;
                if (m_locked) begin
                    m_locked = 1'b0;
                    if (m_err < 255) m_err++;
                end
            end
        end
        e.lk = m_locked;
        e.err = m_err;
        fq.push_back(e);
        model_clear_frame();
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic drive_ce(input bit hs, input bit vs, input bit br, input logic [11:0] c,
                            input bit pv, input int hx, input int vx);
        int idle;
        idle = gap_fixed ? 3 : int'($urandom_range(0, 1));
        for (int i = 0; i < idle; i++) begin
            @(negedge clk);
            pix_ce  = 1'b0;
            hsync_n = 1'($urandom);
            vsync_n = 1'($urandom);
            bright  = 1'($urandom);
            rgb     = 12'($urandom);
        end
        @(negedge clk);
        pix_ce = 1'b1; hsync_n = hs; vsync_n = vs; bright = br; rgb = c;
        pq.push_back('{pv: pv, h: hx, v: vx});
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_ce  = 1'b0;
            hsync_n = 1'($urandom);
            vsync_n = 1'($urandom);
            bright  = 1'($urandom);
            rgb     = 12'($urandom);
        end
    endtask

    task automatic send_line(input int vc, input int len, input bit pause);
        for (int hc = 0; hc < len; hc++) begin
            bit br;
            bit pv;
            logic [11:0] c;
            br = (hc >= H_OFF) && (hc < H_OFF + H_VIS) && (vc >= V_OFF) && (vc < V_OFF + V_VIS);
            c  = 12'($urandom);
            pv = br && m_locked;
            drive_ce(hc >= HS_W, vc >= VS_W, br, c, pv, (hc - H_OFF) & 32'h3FF, (vc - V_OFF) & 32'h3FF);
            if (br) f_sum = (f_sum + int'(c)) & 32'hFFFF;
            if (hc == 0 && vc == 0) model_vs_fall();
            if (pause && hc == H_OFF) begin
                idle_clks(50);
                check("hold_h_pos", h_pos, (hc - H_OFF) & 32'h3FF);
                check("hold_v_pos", v_pos, (vc - V_OFF) & 32'h3FF);
                check("hold_pos_valid", pos_valid, pv);
            end
        end
        f_lines++;
        f_last = len;
        if (len != H_T) f_good = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_ce = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_search = 1'b1; m_locked = 1'b0; m_streak = 0; m_err = 0;
        model_clear_frame();
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_pos_valid", pos_valid, 0);
        check("rst_frame_lines", frame_lines, 0);
        check("rst_line_len", line_len, 0);
        check("rst_h_pos", h_pos, 0);
        check("rst_frame_done", frame_done, 0);
`ifdef VGA_RX_CHECKSUM_EN
        check("rst_frame_sum", frame_sum, 0);
`endif
    endtask

    // lines [first, last) of a frame; optional short line, pause and reset
    task automatic send_frame(input int first, input int last, input int short_line,
                              input int pause_line, input int rst_line);
        for (int vc = first; vc < last; vc++) begin
            if (vc == rst_line) do_reset();
            send_line(vc, (vc == short_line) ? H_T - 1 : H_T, vc == pause_line);
        end
    endtask

    task automatic hold_sync(input int n);
        for (int i = 0; i < n; i++) drive_ce(1'b1, 1'b1, 1'b0, 12'($urandom), 1'b0, 0, 0);
        if (m_locked && m_err < 255) m_err++;
        m_locked = 1'b0;
        m_search = 1'b1;
        m_streak = 0;
        @(posedge clk);
        #1;
        check("loss_locked", locked, 0);
        check("loss_err_count", err_count, m_err);
    endtask

    // ---------------- monitors ----------------
    initial begin : mon_pos
        logic ce_s;
        pexp_t p;
        forever begin
            @(posedge clk);
            ce_s = pix_ce;
            #1;
            if (ce_s === 1'b1 && rst === 1'b0) begin
                if (pq.size() == 0) begin
                    check("pos_queue_empty", 1, 0);
                end else begin
                    p = pq.pop_front();
                    check("pos_valid", pos_valid, p.pv);
                    if (p.pv) begin
                        check("h_pos", h_pos, p.h);
                        check("v_pos", v_pos, p.v);
                    end
                end
            end
        end
    end

    initial begin : mon_frame
        fexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) begin
                if (fq.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    e = fq.pop_front();
                    check("locked", locked, e.lk);
                    check("err_count", err_count, e.err);
                    if (e.meas) begin
                        check("frame_lines", frame_lines, e.fl & 32'h3FF);
                        check("line_len", line_len, e.ll & 32'h3FF);
`ifdef VGA_RX_CHECKSUM_EN
                        check("frame_sum", frame_sum, e.sum);
`endif
                    end
                end
            end
        end
    end

    // ---------------- scenario ----------------
    initial begin : stim
        do_reset();
        // Ideal frames at a fixed ce rate: lock after the 3rd vs_fall.
        gap_fixed = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(0, V_T, -1, -1, -1);
        gap_fixed = 1'b0;
        // Locked frame with a 50-clk ce gap on the first visible pixel.
        send_frame(0, V_T, -1, V_OFF, -1);
        // One short line, then two good frames to relock.
        send_frame(0, V_T, 5, -1, -1);
        for (int f = 0; f < 3; f++) send_frame(0, V_T, -1, -1, -1);
        // One short frame, then relock.
        send_frame(0, V_T - 1, -1, -1, -1);
        for (int f = 0; f < 3; f++) send_frame(0, V_T, -1, -1, -1);
        // Sync loss: hsync held high, then resume mid-frame.
        send_frame(0, 6, -1, -1, -1);
        hold_sync(1100);
        send_frame(8, V_T, -1, -1, -1);
        for (int f = 0; f < 3; f++) send_frame(0, V_T, -1, -1, -1);
        // Reset mid-frame, then reacquire.
        send_frame(0, V_T, -1, -1, 7);
        for (int f = 0; f < 3; f++) send_frame(0, V_T, -1, -1, -1);
        send_line(0, H_T, 1'b0);
        idle_clks(6);
        check("frame_queue_drained", fq.size(), 0);
        check("pos_queue_drained", pq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of display_controller. Samples an hSync/vSync/bright/rgb stream and reconstructs the pixel position.
- Measures line length and frame height, and checks them against nominal 640x480 timing.
- Declares lock after consecutive good frames.
- Used as an on-chip monitor/loopback checker beside the VGA output path, and as a bench-reusable scoreboard front end.

Parameters:
- H_TOTAL, 800, expected pixel clocks per line
- V_TOTAL, 525, expected lines per frame
- H_OFFSET, 144, pixel clocks from hsync fall to first visible pixel
- V_OFFSET, 35, lines from vsync fall to first visible line
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel clock enable; all state advances only when 1
- hsync_n  in  1  active-low horizontal sync
- vsync_n  in  1  active-low vertical sync
- bright  in  1  visible-region flag
- rgb  in  12  pixel colour {R[11:8],G[7:4],B[3:0]}
- h_pos  out  10  reconstructed visible column
- v_pos  out  10  reconstructed visible row
- pos_valid  out  1  h_pos/v_pos valid (bright and locked)
- line_len  out  10  last measured line length in ce cycles
- frame_lines  out  10  last measured lines per frame
- locked  out  1  timing lock
- err_count  out  8  timing error count, saturating at 255
- frame_done  out  1  one-clk pulse per vsync falling edge

Behaviour:
- Reset (async, rst=1): all registers and outputs 0; hs_prev and vs_prev set to 1; FSM = SEARCH.
- Sampling: hs_fall = pix_ce & hs_prev & ~hsync_n; vs_fall defined likewise. hs_prev and vs_prev update only on ce cycles. With pix_ce=0, every register holds.
- h_cnt (10 bit):
  - hs_fall: line_len <= h_cnt+1; h_cnt <= 0; if line_len candidate != H_TOTAL, set sticky line_err.
  - Otherwise h_cnt increments, saturating at 1023.
- v_cnt (10 bit):
  - Increments on each hs_fall.
  - vs_fall: frame_lines <= v_cnt + hs_fall; v_cnt <= 0. A simultaneous hsync edge is counted in the old frame.
- Frame good: frame_lines candidate == V_TOTAL and line_err == 0. line_err clears on vs_fall after evaluation.
- Position outputs (registered, 1 ce latency):
  - h_pos <= h_cnt - H_OFFSET; v_pos <= v_cnt - V_OFFSET, both truncated to 10 bits.
  - pos_valid <= bright & locked.
- FSM (transitions only on vs_fall unless stated):
  - SEARCH: the first vs_fall discards the partial frame -> ACQUIRE, good_cnt=0, line_err cleared.
  - ACQUIRE: good frame -> good_cnt+1; on reaching LOCK_FRAMES -> LOCKED. Bad frame -> good_cnt=0, stay in ACQUIRE.
  - LOCKED: bad frame -> ACQUIRE, good_cnt=0, err_count+1.
  - Any state, on a ce cycle where h_cnt==1023 (sync loss): -> SEARCH; err_count+1 only if leaving LOCKED. h_cnt stays saturated until the next hs_fall.
- locked = (state==LOCKED), registered; it changes in the clk after the deciding vs_fall.
- frame_done: asserted exactly one clk after each vs_fall, including in SEARCH; independent of pix_ce in the following cycle.
- err_count saturates at 255; it is never cleared except by rst.
- Reset mid-frame: state returns to SEARCH; the partial frame that follows is discarded.

Optional Feature:
- Macro: VGA_RX_CHECKSUM_EN.
- Defined:
  - Adds output frame_sum (16 bit).
  - An internal 16-bit accumulator adds zero-extended rgb on each ce cycle with bright=1, wrapping modulo 2^16.
  - On vs_fall, frame_sum <= accumulator (including the current pixel if bright) and the accumulator clears. Both are 0 on reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Ideal 800x525 stream, pix_ce every 4th clk, LOCK_FRAMES=2 -> locked rises 1 clk after the 3rd vs_fall; line_len=800, frame_lines=525, err_count=0.
- Locked, then one line of 799 ce cycles -> at the next vs_fall locked=0, err_count=1. Two further good frames -> locked=1.
- Locked, then frame of 524 lines -> err_count=1, state ACQUIRE, frame_lines=524.
- Locked, then hsync held high for 1100 ce cycles -> locked drops when h_cnt hits 1023, err_count+1, state SEARCH. Resume -> relock after 1+LOCK_FRAMES vs_falls.
- Locked, pixel at hCount=144, vCount=35 with bright=1 -> h_pos=0, v_pos=0, pos_valid=1 one ce later. pix_ce=0 for 50 clks -> all outputs hold.
- VGA_RX_CHECKSUM_EN, rgb=12'h001 on every bright pixel -> frame_sum = 640*480 mod 65536 = 45056. rst mid-frame -> frame_sum=0, locked=0.
